// File: rtl/vblank_scheduler.sv
// Frame-synchronous update scheduler: one round of grants per vertical sync, 4 requesters.
// Define VBLANK_SCHED_RR_EN to rotate the first-served requester each frame (default: fixed 0..3).
module vblank_scheduler #(
  parameter int unsigned SLOT_MAX  = 4096,  // must be >= 2
  parameter logic        VS_ACTIVE = 1'b0
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic        enable,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic        clr_flags,
  output logic [3:0]  gnt,
  output logic        frame_tick,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic [3:0]  timeout_flags
);

  localparam int unsigned SlotW = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SLOT_MAX - 1);

  typedef enum logic [1:0] {StIdle, StScan, StGrant} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       visited_q, visited_d;
  logic [2:0]       visited_inc;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             overrun_q, overrun_d;
  logic [3:0]       tflags_q, tflags_d;
  logic             vs_q, vs_prev_q;
  logic             tick_q, tick_d;
  logic [15:0]      fcnt_q;
  logic [1:0]       start_idx;

  // Tick follows the first registered sample at the active level.
  assign tick_d = (vs_q == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vs_q      <= ~VS_ACTIVE;
      vs_prev_q <= ~VS_ACTIVE;
      tick_q    <= 1'b0;
      fcnt_q    <= 16'd0;
    end else begin
      vs_q      <= vga_vs;
      vs_prev_q <= vs_q;
      tick_q    <= tick_d;
      if (tick_d) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
    end
  end

`ifdef VBLANK_SCHED_RR_EN
  // frame_cnt already holds the post-increment value during the tick cycle.
  assign start_idx = fcnt_q[1:0];
`else
  assign start_idx = 2'd0;
`endif

  assign visited_inc = visited_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    visited_d = visited_q;
    slot_d    = slot_q;
    gnt_d     = gnt_q;
    overrun_d = clr_flags ? 1'b0 : overrun_q;
    tflags_d  = clr_flags ? 4'd0 : tflags_q;

    if (tick_q && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick_q && enable) begin
          state_d   = StScan;
          idx_d     = start_idx;
          visited_d = 3'd0;
        end
      end

      StScan: begin
        if (req[idx_q]) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << idx_q;
          slot_d  = '0;
        end else begin
          idx_d     = idx_q + 2'd1;
          visited_d = visited_inc;
          if (visited_inc == 3'd4) begin
            state_d = StIdle;
          end
        end
      end

      StGrant: begin
        slot_d = slot_q + SlotW'(1);
        if (vga_blank_n) begin
          // Visible region reached mid-grant: abandon the rest of the round.
          gnt_d     = 4'd0;
          overrun_d = 1'b1;
          state_d   = StIdle;
        end else if (done[idx_q] || (slot_q == SlotLast)) begin
          if (!done[idx_q]) begin
            tflags_d[idx_q] = 1'b1;
          end
          gnt_d     = 4'd0;
          idx_d     = idx_q + 2'd1;
          visited_d = visited_inc;
          state_d   = (visited_inc == 3'd4) ? StIdle : StScan;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      visited_q <= 3'd0;
      slot_q    <= '0;
      gnt_q     <= 4'd0;
      overrun_q <= 1'b0;
      tflags_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      visited_q <= visited_d;
      slot_q    <= slot_d;
      gnt_q     <= gnt_d;
      overrun_q <= overrun_d;
      tflags_q  <= tflags_d;
    end
  end

  assign gnt           = gnt_q;
  assign frame_tick    = tick_q;
  assign busy          = (state_q != StIdle);
  assign frame_cnt     = fcnt_q;
  assign overrun       = overrun_q;
  assign timeout_flags = tflags_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Self-checking bench for vblank_scheduler: randomized rounds against a round-level model,
// plus directed abort, enable, double-tick and mid-grant reset scenarios.
module tb_vblank_scheduler;

  localparam int unsigned SlotMax = 16;
  localparam logic        VsAct   = 1'b0;
  localparam int          Never   = 1000;

  logic        clk_vga = 1'b0;
  logic        rst, vga_vs, vga_blank_n, enable, clr_flags;
  logic [3:0]  req, done, gnt, timeout_flags;
  logic        frame_tick, busy, overrun;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  int         dly [4];
  int         r_cnt;
  logic [3:0] r_prev;

  logic [3:0] seq_gnt[$];
  int         seq_len[$];
  logic [3:0] last_gnt;
  int         busy_cycles, onehot_bad, ticks_seen;
  int         exp_fc;

  vblank_scheduler #(
    .SLOT_MAX (SlotMax),
    .VS_ACTIVE(VsAct)
  ) dut (
    .clk_vga      (clk_vga),
    .rst          (rst),
    .vga_vs       (vga_vs),
    .vga_blank_n  (vga_blank_n),
    .enable       (enable),
    .req          (req),
    .done         (done),
    .clr_flags    (clr_flags),
    .gnt          (gnt),
    .frame_tick   (frame_tick),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .overrun      (overrun),
    .timeout_flags(timeout_flags)
  );

  always #5 clk_vga = ~clk_vga;

  // Requester model: answers done dly[i] cycles into its grant (cycle 0 = first gnt cycle).
  initial begin
    done   = 4'd0;
    r_cnt  = 0;
    r_prev = 4'd0;
    forever begin
      @(posedge clk_vga);
      #1;
      if (gnt != 4'd0 && gnt == r_prev) r_cnt++;
      else r_cnt = 0;
      r_prev = gnt;
      done = 4'd0;
      for (int i = 0; i < 4; i++) begin
        if (gnt == (4'b0001 << i) && r_cnt == dly[i]) done = gnt;
      end
    end
  end

  task automatic step();
    @(posedge clk_vga);
    #1;
    if ($countones(gnt) > 1) onehot_bad++;
    if (busy === 1'b1) busy_cycles++;
    if (frame_tick === 1'b1) ticks_seen++;
    if (gnt != 4'd0) begin
      if (gnt != last_gnt) begin
        seq_gnt.push_back(gnt);
        seq_len.push_back(1);
      end else begin
        seq_len[seq_len.size()-1]++;
      end
    end
    last_gnt = gnt;
  endtask

  task automatic clear_rec();
    seq_gnt.delete();
    seq_len.delete();
    busy_cycles = 0;
    onehot_bad  = 0;
    ticks_seen  = 0;
  endtask

  task automatic frame();
    vga_vs = VsAct;
    step();
    step();
    vga_vs = ~VsAct;
    step();
    exp_fc++;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    int n = 0;
    while (gnt == 4'd0 && n < 60) begin
      step();
      n++;
    end
    ok = (gnt != 4'd0);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (!(busy_cycles > 0 && busy === 1'b0) && n < 400) begin
      step();
      n++;
    end
    ok = (n < 400);
  endtask

  function automatic logic [1:0] model_start();
`ifdef VBLANK_SCHED_RR_EN
    logic [31:0] fc = exp_fc;
    return fc[1:0];
`else
    return 2'd0;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; vga_vs = ~VsAct; vga_blank_n = 1'b0; enable = 1'b1;
    req = 4'd0; clr_flags = 1'b0; exp_fc = 0; last_gnt = 4'd0;
    for (int i = 0; i < 4; i++) dly[i] = Never;
    repeat (3) step();
    checks++; if (gnt !== 4'd0) begin failures++; $display("FAIL reset_gnt: got %h want 0", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_fcnt: got %h want 0", frame_cnt); end
    checks++; if (overrun !== 1'b0 || timeout_flags !== 4'd0 || frame_tick !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got ovr=%b to=%h tick=%b want 0", overrun, timeout_flags, frame_tick);
    end
    rst = 1'b0;
    clear_rec();
    repeat (4) step();
    checks++; if (ticks_seen != 0) begin failures++; $display("FAIL reset_no_tick: got %0d ticks want 0", ticks_seen); end
  endtask

  // Round-level model: slots visited from start in order, hold = min(dly+1, SlotMax).
  task automatic test_rounds();
    for (int t = 0; t < 14; t++) begin
      logic [3:0] eg[$];
      int         el[$];
      logic [3:0] eto;
      int         eb, h, i;
      logic [1:0] s;
      bit         ok;
      case (t)
        0: begin req = 4'b0101; dly = '{10, Never, 10, Never}; end
        1: begin req = 4'b0010; dly = '{Never, Never, Never, Never}; end
        2: begin req = 4'b1111; dly = '{0, 0, 0, 0}; end
        3: begin req = 4'b0000; dly = '{0, 0, 0, 0}; end
        4: begin req = 4'b1001; dly = '{15, 0, 0, 16}; end
        default: begin
          req = 4'($urandom_range(0, 15));
          for (int k = 0; k < 4; k++) dly[k] = $urandom_range(0, 20);
        end
      endcase
      pulse_clr();
      checks++; if (timeout_flags !== 4'd0) begin failures++; $display("FAIL clr_to[%0d]: got %h want 0", t, timeout_flags); end
      clear_rec();
      frame();
      s = model_start();
      wait_idle(ok);
      checks++; if (!ok) begin failures++; $display("FAIL round_end[%0d]: got busy want idle", t); end
      eto = 4'd0;
      eb  = 4;
      for (int k = 0; k < 4; k++) begin
        i = (int'(s) + k) % 4;
        if (req[i]) begin
          h = (dly[i] + 1 <= int'(SlotMax)) ? dly[i] + 1 : int'(SlotMax);
          eg.push_back(4'b0001 << i);
          el.push_back(h);
          eb += h;
          if (dly[i] >= int'(SlotMax)) eto[i] = 1'b1;
        end
      end
      checks++;
      if (seq_gnt.size() != eg.size()) begin
        failures++; $display("FAIL grant_count[%0d]: got %0d want %0d", t, seq_gnt.size(), eg.size());
      end else begin
        for (int k = 0; k < eg.size(); k++) begin
          checks++;
          if (seq_gnt[k] !== eg[k] || seq_len[k] != el[k]) begin
            failures++;
            $display("FAIL grant[%0d.%0d]: got %h x%0d want %h x%0d", t, k, seq_gnt[k], seq_len[k], eg[k], el[k]);
          end
        end
      end
      checks++; if (timeout_flags !== eto) begin failures++; $display("FAIL timeout[%0d]: got %h want %h", t, timeout_flags, eto); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun[%0d]: got %b want 0", t, overrun); end
      checks++; if (busy_cycles != eb) begin failures++; $display("FAIL busy_len[%0d]: got %0d want %0d", t, busy_cycles, eb); end
      checks++; if (onehot_bad != 0) begin failures++; $display("FAIL onehot[%0d]: got %0d bad want 0", t, onehot_bad); end
      checks++; if (frame_cnt !== 16'(exp_fc)) begin failures++; $display("FAIL fcnt[%0d]: got %0d want %0d", t, frame_cnt, exp_fc); end
      repeat (2) step();
    end
  endtask

  task automatic test_enable();
    bit ok;
    enable = 1'b0; req = 4'b1111; dly = '{0, 0, 0, 0};
    clear_rec();
    frame();
    repeat (6) step();
    checks++; if (busy_cycles != 0) begin failures++; $display("FAIL disabled_busy: got %0d want 0", busy_cycles); end
    checks++; if (frame_cnt !== 16'(exp_fc)) begin failures++; $display("FAIL disabled_fcnt: got %0d want %0d", frame_cnt, exp_fc); end
    enable = 1'b1; req = 4'b0011; dly = '{3, 3, 0, 0};
    clear_rec();
    frame();
    wait_gnt(ok);
    enable = 1'b0;
    wait_idle(ok);
    checks++; if (!ok || seq_gnt.size() != 2 || busy_cycles != 12) begin
      failures++; $display("FAIL mid_disable: got %0d grants %0d busy want 2 grants 12 busy", seq_gnt.size(), busy_cycles);
    end
    enable = 1'b1;
  endtask

  task automatic test_abort();
    bit ok;
    req = 4'b0001; dly = '{Never, Never, Never, Never};
    pulse_clr();
    clear_rec();
    frame();
    wait_gnt(ok);
    repeat (2) step();
    vga_blank_n = 1'b1;
    clr_flags   = 1'b1;  // set must win over clear
    step();
    clr_flags = 1'b0;
    checks++; if (gnt !== 4'd0) begin failures++; $display("FAIL abort_gnt: got %h want 0", gnt); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL abort_ovr: got %b want 1", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
    vga_blank_n = 1'b0;
    pulse_clr();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL clr_ovr: got %b want 0", overrun); end
  endtask

  task automatic test_double_tick_and_reset();
    bit ok;
    req = 4'b0001; dly = '{Never, Never, Never, Never};
    pulse_clr();
    clear_rec();
    frame();
    wait_gnt(ok);
    vga_vs = VsAct;  step();
    vga_vs = ~VsAct; step();
    vga_vs = VsAct;  step();
    vga_vs = ~VsAct; step();
    step(); step();
    exp_fc += 2;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL dbl_ovr: got %b want 1", overrun); end
    checks++; if (frame_cnt !== 16'(exp_fc)) begin failures++; $display("FAIL dbl_fcnt: got %0d want %0d", frame_cnt, exp_fc); end
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL dbl_gnt: got %h want 1", gnt); end
    wait_idle(ok);
    checks++; if (!ok || seq_gnt.size() != 1 || seq_len[0] != int'(SlotMax) || busy_cycles != 4 + int'(SlotMax)) begin
      failures++; $display("FAIL dbl_restart: got %0d grants %0d busy want 1 grant %0d busy", seq_gnt.size(), busy_cycles, 4 + SlotMax);
    end
    checks++; if (timeout_flags !== 4'b0001) begin failures++; $display("FAIL dbl_to: got %h want 1", timeout_flags); end
    clear_rec();
    frame();
    wait_gnt(ok);
    rst = 1'b1;
    step();
    checks++; if (gnt !== 4'd0 || busy !== 1'b0 || frame_tick !== 1'b0) begin
      failures++; $display("FAIL midrst_gnt: got gnt=%h busy=%b tick=%b want 0", gnt, busy, frame_tick);
    end
    checks++; if (frame_cnt !== 16'd0 || overrun !== 1'b0 || timeout_flags !== 4'd0) begin
      failures++; $display("FAIL midrst_flags: got fc=%0d ovr=%b to=%h want 0", frame_cnt, overrun, timeout_flags);
    end
    rst = 1'b0;
    exp_fc = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_rounds();
    test_enable();
    test_abort();
    test_double_tick_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
